// File: rtl/spram_power_ctrl.sv
// Power-state controller for the instruction SPRAMs: walks ACTIVE -> STBY -> SLEEP
// while the core idles in WFI, and sequences a timed WAKE before fetches resume.
module spram_power_ctrl #(
    parameter int unsigned SLEEP_DELAY = 64,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wfi,
    input  logic        wake,
    output logic        spram_standby,
    output logic        spram_sleep,
    output logic        spram_poweroff_n,
    output logic        mem_ready,
    output logic [1:0]  pstate,
    output logic [31:0] sleep_cycles
);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        STBY   = 2'd1,
        SLEEP  = 2'd2,
        WAKE   = 2'd3
    } pstate_e;

    localparam bit          ESCALATE  = (SLEEP_DELAY != 0);
    localparam bit          USE_WAKE  = (WAKE_CYCLES != 0);
    localparam logic [15:0] IDLE_LAST = ESCALATE ? 16'(SLEEP_DELAY - 1) : 16'd0;
    localparam logic [3:0]  WAKE_LOAD = USE_WAKE ? 4'(WAKE_CYCLES - 1) : 4'd0;

    pstate_e     state_q, state_d;
    logic [15:0] idle_cnt, idle_d;
    logic [3:0]  wake_cnt, wake_d;
    logic        w;

    assign w                = wake | ~wfi;
    assign pstate           = state_q;
    // Instruction contents must always be retained, so the array is never powered off.
    assign spram_poweroff_n = 1'b1;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        idle_d  = idle_cnt;
        wake_d  = wake_cnt;
        case (state_q)
            ACTIVE: begin
                if (wfi && !wake) begin
                    state_d = STBY;
                    idle_d  = 16'd0;
                end
            end
            STBY: begin
                // A wake request outranks escalation to SLEEP in the same cycle.
                if (w) begin
                    state_d = USE_WAKE ? WAKE : ACTIVE;
                    wake_d  = WAKE_LOAD;
                end else if (ESCALATE && idle_cnt == IDLE_LAST) begin
                    state_d = SLEEP;
                end else if (idle_cnt != 16'hFFFF) begin
                    idle_d = idle_cnt + 16'd1;
                end
            end
            SLEEP: begin
                if (w) begin
                    state_d = USE_WAKE ? WAKE : ACTIVE;
                    wake_d  = WAKE_LOAD;
                end
            end
            WAKE: begin
                if (wake_cnt == 4'd0) state_d = ACTIVE;
                else                  wake_d  = wake_cnt - 4'd1;
            end
            default: state_d = ACTIVE;
        endcase
    end

    // Outputs are registered from the next state so they always match pstate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ACTIVE;
            idle_cnt      <= 16'd0;
            wake_cnt      <= 4'd0;
            spram_standby <= 1'b0;
            spram_sleep   <= 1'b0;
            mem_ready     <= 1'b1;
            sleep_cycles  <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q       <= state_d;
            idle_cnt      <= idle_d;
            wake_cnt      <= wake_d;
            spram_standby <= (state_d == STBY) || (state_d == SLEEP);
            spram_sleep   <= (state_d == SLEEP);
            mem_ready     <= (state_d == ACTIVE);
            if (state_q == SLEEP && sleep_cycles != 32'hFFFF_FFFF)
                sleep_cycles <= sleep_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_spram_power_ctrl.sv
// Directed bench for spram_power_ctrl: default instance for sleep/wake/reset/saturation,
// plus a SLEEP_DELAY=0, WAKE_CYCLES=0 instance for the no-escalation path.
module tb_spram_power_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wfi, wake;
    logic        standby, sleep, poff_n, ready;
    logic [1:0]  pst;
    logic [31:0] scyc;

    logic        wfi2, wake2;
    logic        standby2, sleep2, poff_n2, ready2;
    logic [1:0]  pst2;
    logic [31:0] scyc2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    spram_power_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wfi(wfi), .wake(wake),
        .spram_standby(standby), .spram_sleep(sleep), .spram_poweroff_n(poff_n),
        .mem_ready(ready), .pstate(pst), .sleep_cycles(scyc)
    );

    spram_power_ctrl #(.SLEEP_DELAY(0), .WAKE_CYCLES(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .wfi(wfi2), .wake(wake2),
        .spram_standby(standby2), .spram_sleep(sleep2), .spram_poweroff_n(poff_n2),
        .mem_ready(ready2), .pstate(pst2), .sleep_cycles(scyc2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Invariants on both instances, every cycle.
    always @(negedge clk) begin
        check("inv_sleep_implies_stby",  {31'd0, sleep & ~standby},   32'd0);
        check("inv_poweroff_n",          {31'd0, poff_n},             32'd1);
        check("inv2_sleep_implies_stby", {31'd0, sleep2 & ~standby2}, 32'd0);
        check("inv2_poweroff_n",         {31'd0, poff_n2},            32'd1);
    end

    initial begin
        bit left_stby;
        rst_n = 1'b0; wfi = 1'b0; wake = 1'b0; wfi2 = 1'b0; wake2 = 1'b0;

        // Reset state
        tick(1);
        check("rst_pstate",  {30'd0, pst},       32'd0);
        check("rst_standby", {31'd0, standby},   32'd0);
        check("rst_sleep",   {31'd0, sleep},     32'd0);
        check("rst_ready",   {31'd0, ready},     32'd1);
        check("rst_scyc",    scyc,               32'd0);
        check("rst_idle",    {16'd0, dut.idle_cnt}, 32'd0);
        check("rst_wcnt",    {28'd0, dut.wake_cnt}, 32'd0);

        // wfi to sleep: STBY after 1 edge, SLEEP after 65
        rst_n = 1'b1; wfi = 1'b1;
        tick(1);
        check("stby_pstate",  {30'd0, pst},     32'd1);
        check("stby_standby", {31'd0, standby}, 32'd1);
        check("stby_sleep",   {31'd0, sleep},   32'd0);
        check("stby_ready",   {31'd0, ready},   32'd0);
        tick(63);
        check("edge64_still_stby", {30'd0, pst}, 32'd1);
        tick(1);
        check("edge65_sleep_pstate", {30'd0, pst},   32'd2);
        check("edge65_spram_sleep",  {31'd0, sleep}, 32'd1);
        check("sleep_entry_scyc",    scyc,           32'd0);
        tick(4);
        check("scyc_after_4", scyc, 32'd4);

        // wake from sleep: 2 WAKE cycles, ready on 3rd edge, counter frozen
        wake = 1'b1;
        tick(1);
        wake = 1'b0;
        check("wake1_pstate", {30'd0, pst},   32'd3);
        check("wake1_ready",  {31'd0, ready}, 32'd0);
        check("wake1_scyc",   scyc,           32'd5);
        tick(1);
        check("wake2_pstate", {30'd0, pst}, 32'd3);
        check("wake2_scyc",   scyc,         32'd5);
        tick(1);
        check("wake3_active",  {30'd0, pst},     32'd0);
        check("wake3_ready",   {31'd0, ready},   32'd1);
        check("wake3_standby", {31'd0, standby}, 32'd0);
        // wfi still high: straight back to STBY, no ACTIVE dwell
        tick(1);
        check("reenter_stby", {30'd0, pst}, 32'd1);
        check("reenter_scyc", scyc,         32'd5);
        tick(64);
        check("resleep_pstate", {30'd0, pst}, 32'd2);
        tick(2);

        // async reset in SLEEP, checked before the next edge
        #2 rst_n = 1'b0;
        #1;
        check("arst_sleep",   {31'd0, sleep},   32'd0);
        check("arst_standby", {31'd0, standby}, 32'd0);
        check("arst_ready",   {31'd0, ready},   32'd1);
        check("arst_pstate",  {30'd0, pst},     32'd0);
        check("arst_scyc",    scyc,             32'd0);
        tick(1);
        rst_n = 1'b1;

        // wake beats escalation when idle counter is 63
        tick(1);
        check("race_stby", {30'd0, pst}, 32'd1);
        tick(63);
        check("race_idle63", {16'd0, dut.idle_cnt}, 32'd63);
        check("race_still_stby", {30'd0, pst}, 32'd1);
        wake = 1'b1;
        tick(1);
        check("race_wake_pstate", {30'd0, pst},   32'd3);
        check("race_no_sleep",    {31'd0, sleep}, 32'd0);
        check("race_scyc",        scyc,           32'd0);
        wake = 1'b0; wfi = 1'b0;
        tick(2);
        check("race_active", {30'd0, pst},   32'd0);
        check("race_ready",  {31'd0, ready}, 32'd1);

        // saturation of sleep_cycles
        wfi = 1'b1;
        tick(65);
        check("sat_in_sleep", {30'd0, pst}, 32'd2);
        force dut.sleep_cycles = 32'hFFFF_FFFE;
        #1 release dut.sleep_cycles;
        tick(1);
        check("sat_reach", scyc, 32'hFFFF_FFFF);
        tick(1);
        check("sat_hold1", scyc, 32'hFFFF_FFFF);
        tick(1);
        check("sat_hold2", scyc, 32'hFFFF_FFFF);
        wfi = 1'b0;
        tick(3);
        check("sat_exit_active", {30'd0, pst}, 32'd0);

        // SLEEP_DELAY=0, WAKE_CYCLES=0: STBY held for 70000 cycles, then direct ACTIVE
        wfi2 = 1'b1;
        tick(1);
        check("nd_stby", {30'd0, pst2}, 32'd1);
        left_stby = 1'b0;
        for (int i = 1; i < 70000; i++) begin
            tick(1);
            if (pst2 != 2'd1) left_stby = 1'b1;
        end
        check("nd_held_stby", {31'd0, left_stby}, 32'd0);
        check("nd_idle_sat",  {16'd0, dut2.idle_cnt}, 32'd65535);
        check("nd_scyc",      scyc2, 32'd0);
        wfi2 = 1'b0;
        tick(1);
        check("nd_active",  {30'd0, pst2},     32'd0);
        check("nd_ready",   {31'd0, ready2},   32'd1);
        check("nd_standby", {31'd0, standby2}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spram_power_ctrl.md
SPRAM_POWER_CTRL -- requirements
Module: spram_power_ctrl

Interface
REQ-001 Parameter SLEEP_DELAY, default 64: STBY cycles before escalating to SLEEP; 0 disables SLEEP; legal range 0..65535.
REQ-002 Parameter WAKE_CYCLES, default 2: cycles in WAKE before memory is ready; legal range 0..15.
REQ-003 Port clk, input, 1: core clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port wfi, input, 1: core wait-for-interrupt flag.
REQ-006 Port wake, input, 1: interrupt pending / wake request.
REQ-007 Port spram_standby, output, 1: drives the STANDBY pin of all instruction SPRAMs.
REQ-008 Port spram_sleep, output, 1: drives the SLEEPMODE pin of all instruction SPRAMs.
REQ-009 Port spram_poweroff_n, output, 1: drives the POWEROFF pin; constant 1, because instruction contents are never dropped.
REQ-010 Port mem_ready, output, 1: 1 means fetch data is valid; the core stalls while it is 0.
REQ-011 Port pstate, output, 2: current state; ACTIVE=0, STBY=1, SLEEP=2, WAKE=3.
REQ-012 Port sleep_cycles, output, 32: count of cycles spent in SLEEP.

Function
REQ-013 The controller SHALL be a single FSM with states ACTIVE, STBY, SLEEP and WAKE.
REQ-014 All outputs SHALL be registered, and each output SHALL be a function of state only:
- ACTIVE: standby=0, sleep=0, ready=1.
- STBY: standby=1, sleep=0, ready=0.
- SLEEP: standby=1, sleep=1, ready=0.
- WAKE: standby=0, sleep=0, ready=0.
REQ-015 The wake condition SHALL be w = wake | ~wfi.
REQ-016 In ACTIVE, if wfi=1 and wake=0, the next state SHALL be STBY and the idle counter SHALL be cleared to 0; otherwise the state SHALL remain ACTIVE.
REQ-017 In STBY, if w=1 the next state SHALL be WAKE, taking priority over escalation in the same cycle.
REQ-018 In STBY, if w=0 and SLEEP_DELAY!=0 and the idle counter equals SLEEP_DELAY-1, the next state SHALL be SLEEP; otherwise the idle counter SHALL increment.
REQ-019 With SLEEP_DELAY=0 the controller SHALL remain in STBY until w=1, and the idle counter SHALL saturate at 65535.
REQ-020 In SLEEP, if w=1 the next state SHALL be WAKE; otherwise the state SHALL remain SLEEP.
REQ-021 On entry to WAKE the wake counter SHALL load WAKE_CYCLES-1.
REQ-022 In WAKE the wake counter SHALL decrement, and the state SHALL move to ACTIVE in the cycle after the counter reads 0.
REQ-023 In WAKE, wake and wfi SHALL be ignored.
REQ-024 If WAKE_CYCLES=0, STBY and SLEEP SHALL transition directly to ACTIVE on w=1, bypassing WAKE.
REQ-025 Wake latency, measured from the cycle w=1 is sampled to mem_ready=1, SHALL be exactly WAKE_CYCLES+1 cycles.
REQ-026 wfi=1 re-sampled in the first ACTIVE cycle after a wake SHALL re-enter STBY; there is no minimum ACTIVE dwell.
REQ-027 sleep_cycles SHALL increment by 1 in every cycle pstate=SLEEP.
REQ-028 sleep_cycles SHALL saturate at 0xFFFFFFFF and SHALL NOT wrap.
REQ-029 spram_sleep SHALL never be 1 while spram_standby is 0.
REQ-030 spram_poweroff_n SHALL never be 0.

Reset
REQ-031 While rst_n=0:
- pstate=ACTIVE
- spram_standby=0, spram_sleep=0, spram_poweroff_n=1, mem_ready=1
- idle counter=0, wake counter=0, sleep_cycles=0
REQ-032 Reset asserted in any state, including SLEEP and WAKE, SHALL force the REQ-031 values immediately, without waiting for a clock edge.
REQ-033 The first post-reset edge SHALL evaluate from ACTIVE.

Verification
REQ-034 Scenario "wfi to sleep":
- Stimulus: defaults; wfi=1, wake=0 held.
- Response: STBY after 1 edge; SLEEP after 65 edges, with spram_sleep=1.
REQ-035 Scenario "wake from sleep":
- Stimulus: in SLEEP, pulse wake=1 for 1 cycle.
- Response: WAKE for 2 cycles; mem_ready=1 on the 3rd edge; sleep_cycles frozen.
REQ-036 Scenario "wake beats escalation":
- Stimulus: wake=1 in the same cycle the idle counter equals 63.
- Response: next state is WAKE, never SLEEP; sleep_cycles stays 0.
REQ-037 Scenario "WAKE_CYCLES=0, SLEEP_DELAY=0":
- Stimulus: wfi for 70000 cycles, then wfi=0.
- Response: STBY held throughout; ACTIVE with mem_ready=1 on the next edge.
REQ-038 Scenario "async reset in SLEEP":
- Stimulus: rst_n=0 mid-cycle while in SLEEP.
- Response: spram_sleep=0, spram_standby=0, mem_ready=1 before the next edge; sleep_cycles=0.
REQ-039 Scenario "saturation":
- Stimulus: force sleep_cycles to 0xFFFFFFFE, then hold SLEEP for 3 cycles.
- Response: sleep_cycles reads 0xFFFFFFFF and holds there.
- Checked every cycle throughout the bench: spram_sleep implies spram_standby.
